// File: rtl/edgesr_bank.sv
// Edge-triggered set/reset register bank.
// Per channel: synchronise async set/clear strobes, detect edges of the
// selected polarity, hold a level in q, and optionally auto-clear it after
// a fixed number of cycles high. Registered pulses mark every q transition.
module edgesr_bank #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SET_EDGE     = 0,
  parameter int CLR_EDGE     = 0,
  parameter int SET_PRIORITY = 1,
  parameter int TIMEOUT      = 0,
  parameter int RETRIG       = 1
) (
  input  logic                clk,
  input  logic                resetedge,
  input  logic [CHANNELS-1:0] set_in,
  input  logic [CHANNELS-1:0] clr_in,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] set_pulse,
  output logic [CHANNELS-1:0] clr_pulse,
  output logic [CHANNELS-1:0] tmo_pulse,
  output logic                any_q
);

  localparam int          ARM_W    = $clog2(SYNC_STAGES + 2) + 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  // Edge of the requested polarity: 0 rising, 1 falling, 2 either.
  function automatic logic [CHANNELS-1:0] edge_detect(
    input logic [CHANNELS-1:0] now,
    input logic [CHANNELS-1:0] hist,
    input int                  mode
  );
    if (mode == 0)      return now & ~hist;
    else if (mode == 1) return ~now & hist;
    else                return now ^ hist;
  endfunction

  // Index 0 is the flop nearest the pins; SYNC_STAGES-1 is the settled one.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] set_sync, clr_sync;
  logic [CHANNELS-1:0]                  set_hist, clr_hist;
  logic [ARM_W-1:0]                     arm_cnt;
  logic                                 armed;
  logic [CHANNELS-1:0][15:0]            cnt, cnt_nxt;
  logic [CHANNELS-1:0]                  q_nxt, tmo_nxt;
  logic [CHANNELS-1:0]                  set_evt, clr_evt;

  // Synchroniser chains plus one history flop per input.
  always_ff @(posedge clk or posedge resetedge) begin
    if (resetedge) begin
      set_sync <= '0;
      clr_sync <= '0;
      set_hist <= '0;
      clr_hist <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        set_sync <= {set_sync[SYNC_STAGES-2:0], set_in};
        clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_in};
      end else begin
        set_sync <= set_in;
        clr_sync <= clr_in;
      end
      set_hist <= set_sync[SYNC_STAGES-1];
      clr_hist <= clr_sync[SYNC_STAGES-1];
    end
  end

  // Arm once the sync chain and history flop hold post-reset samples, so
  // levels already present at release never look like edges.
  always_ff @(posedge clk or posedge resetedge) begin
    if (resetedge) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      armed   <= (arm_cnt == ARM_W'(SYNC_STAGES));
    end
  end

  // Qualified edge events.
  always_comb begin
    set_evt = '0;
    clr_evt = '0;
    if (armed) begin
      set_evt = edge_detect(set_sync[SYNC_STAGES-1], set_hist, SET_EDGE);
      clr_evt = edge_detect(clr_sync[SYNC_STAGES-1], clr_hist, CLR_EDGE);
    end
  end

  // Per-channel next state: conflict resolution, set, clear, timeout, count.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    tmo_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic s, c, expire;
      s      = set_evt[i];
      c      = clr_evt[i];
      expire = TMO_EN && q[i] && (cnt[i] == TMO_LAST);
      if (s && c) begin
        if (SET_PRIORITY != 0) c = 1'b0;
        else                   s = 1'b0;
      end
      if (s) begin
        q_nxt[i] = 1'b1;
        // A set landing on expiry keeps q high and restarts the count even
        // without retriggering, otherwise the counter would run past the end.
        if (!q[i] || (RETRIG != 0) || expire) cnt_nxt[i] = 16'd0;
        else                                  cnt_nxt[i] = cnt[i] + 16'd1;
      end else if (c) begin
        q_nxt[i]   = 1'b0;
        cnt_nxt[i] = 16'd0;
      end else if (expire) begin
        q_nxt[i]   = 1'b0;
        tmo_nxt[i] = 1'b1;
        cnt_nxt[i] = 16'd0;
      end else if (q[i]) begin
        cnt_nxt[i] = cnt[i] + 16'd1;
      end
      if (!TMO_EN) cnt_nxt[i] = 16'd0;
    end
  end

  // Held levels, counters and pulses derived from the actual q transition.
  always_ff @(posedge clk or posedge resetedge) begin
    if (resetedge) begin
      q         <= '0;
      cnt       <= '0;
      set_pulse <= '0;
      clr_pulse <= '0;
      tmo_pulse <= '0;
    end else begin
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      set_pulse <= q_nxt & ~q;
      clr_pulse <= ~q_nxt & q;
      tmo_pulse <= tmo_nxt;
    end
  end

  // Aggregate flag, one cycle behind q.
  always_ff @(posedge clk or posedge resetedge) begin
    if (resetedge) any_q <= 1'b0;
    else           any_q <= |q;
  end

endmodule

// File: tb/tb_edgesr_bank.sv
// Bench for edgesr_bank: four differently configured instances share random
// set/clear strobes; a cycle-indexed behavioural model predicts every output.
module tb_edgesr_bank;

  localparam int NI = 4;
  // Instance configurations: sync stages, set edge, clear edge, priority, timeout, retrig.
  int p_s  [NI] = '{2, 2, 3, 2};
  int p_se [NI] = '{0, 1, 2, 0};
  int p_ce [NI] = '{0, 2, 1, 0};
  int p_pri[NI] = '{1, 0, 1, 0};
  int p_t  [NI] = '{10, 10, 0, 5};
  int p_rt [NI] = '{1, 0, 1, 0};

  logic       clk = 1'b0;
  logic       resetedge = 1'b1;
  logic [3:0] set_in = 4'hF;
  logic [3:0] clr_in = 4'h0;
  logic [3:0] dq[NI], dsp[NI], dcp[NI], dtp[NI];
  logic       dany[NI];

  always #5 clk = ~clk;

  edgesr_bank #(.CHANNELS(4), .SYNC_STAGES(2), .SET_EDGE(0), .CLR_EDGE(0),
                .SET_PRIORITY(1), .TIMEOUT(10), .RETRIG(1)) u0 (
    .clk(clk), .resetedge(resetedge), .set_in(set_in), .clr_in(clr_in),
    .q(dq[0]), .set_pulse(dsp[0]), .clr_pulse(dcp[0]), .tmo_pulse(dtp[0]), .any_q(dany[0]));
  edgesr_bank #(.CHANNELS(4), .SYNC_STAGES(2), .SET_EDGE(1), .CLR_EDGE(2),
                .SET_PRIORITY(0), .TIMEOUT(10), .RETRIG(0)) u1 (
    .clk(clk), .resetedge(resetedge), .set_in(set_in), .clr_in(clr_in),
    .q(dq[1]), .set_pulse(dsp[1]), .clr_pulse(dcp[1]), .tmo_pulse(dtp[1]), .any_q(dany[1]));
  edgesr_bank #(.CHANNELS(4), .SYNC_STAGES(3), .SET_EDGE(2), .CLR_EDGE(1),
                .SET_PRIORITY(1), .TIMEOUT(0), .RETRIG(1)) u2 (
    .clk(clk), .resetedge(resetedge), .set_in(set_in), .clr_in(clr_in),
    .q(dq[2]), .set_pulse(dsp[2]), .clr_pulse(dcp[2]), .tmo_pulse(dtp[2]), .any_q(dany[2]));
  edgesr_bank #(.CHANNELS(4), .SYNC_STAGES(2), .SET_EDGE(0), .CLR_EDGE(0),
                .SET_PRIORITY(0), .TIMEOUT(5), .RETRIG(0)) u3 (
    .clk(clk), .resetedge(resetedge), .set_in(set_in), .clr_in(clr_in),
    .q(dq[3]), .set_pulse(dsp[3]), .clr_pulse(dcp[3]), .tmo_pulse(dtp[3]), .any_q(dany[3]));

  int errors = 0;
  int checks = 0;
  int tmo_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: input samples indexed by clock edge since reset release.
  logic [3:0] si[8192], ci[8192];
  int         n = 0;
  logic [3:0] mq[NI], esp[NI], ecp[NI], etp[NI];
  logic       eany[NI];
  int         dl[NI][4];

  function automatic logic [3:0] edg(input logic [3:0] now, input logic [3:0] was, input int mode);
    if (mode == 0)      return now & ~was;
    else if (mode == 1) return ~now & was;
    else                return now ^ was;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NI; k++) begin
      mq[k] = 0; esp[k] = 0; ecp[k] = 0; etp[k] = 0; eany[k] = 0;
      for (int c = 0; c < 4; c++) dl[k][c] = 0;
    end
  endtask

  // One clock edge of instance k. The decision at edge n sees the input
  // sampled at edge n-S against the one before; nothing counts until both
  // of those samples were taken after release.
  task automatic model_step(input int k);
    logic [3:0] pq, se, ce;
    logic s, c, exp_now;
    pq = mq[k];
    eany[k] = |pq;
    etp[k] = 0;
    se = 0; ce = 0;
    if (n >= p_s[k] + 2) begin
      se = edg(si[n - p_s[k]], si[n - p_s[k] - 1], p_se[k]);
      ce = edg(ci[n - p_s[k]], ci[n - p_s[k] - 1], p_ce[k]);
    end
    for (int ch = 0; ch < 4; ch++) begin
      s = se[ch]; c = ce[ch];
      if (s && c) begin
        if (p_pri[k] != 0) c = 0; else s = 0;
      end
      exp_now = pq[ch] && (p_t[k] != 0) && (n == dl[k][ch]);
      if (s) begin
        if (!pq[ch] || p_rt[k] != 0 || exp_now) dl[k][ch] = n + p_t[k];
        mq[k][ch] = 1'b1;
      end else if (c) begin
        mq[k][ch] = 1'b0;
      end else if (exp_now) begin
        mq[k][ch] = 1'b0;
        etp[k][ch] = 1'b1;
        tmo_seen++;
      end
    end
    esp[k] = mq[k] & ~pq;
    ecp[k] = ~mq[k] & pq;
  endtask

  // Stimulus: every level is held at least two clock periods.
  int sage[4], cage[4];
  task automatic drive();
    logic tog;
    for (int ch = 0; ch < 4; ch++) begin
      sage[ch]++; cage[ch]++;
      tog = 0;
      if (sage[ch] >= 2 && $urandom_range(0, 1 + 2 * ch) == 0) begin
        set_in[ch] = ~set_in[ch]; sage[ch] = 0; tog = 1;
      end
      if (cage[ch] >= 2) begin
        if ((tog && $urandom_range(0, 2) == 0) || $urandom_range(0, 3 + 3 * ch) == 0) begin
          clr_in[ch] = ~clr_in[ch]; cage[ch] = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    for (int ch = 0; ch < 4; ch++) begin sage[ch] = 0; cage[ch] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (resetedge) model_reset();
      else begin
        n++;
        si[n] = set_in; ci[n] = clr_in;
        for (int k = 0; k < NI; k++) model_step(k);
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        check($sformatf("q%0d", k),   dq[k],   mq[k]);
        check($sformatf("sp%0d", k),  dsp[k],  esp[k]);
        check($sformatf("cp%0d", k),  dcp[k],  ecp[k]);
        check($sformatf("tp%0d", k),  dtp[k],  etp[k]);
        check($sformatf("any%0d", k), dany[k], eany[k]);
      end
      if (cyc == 4 || cyc == 1504) resetedge = 1'b0;
      if (cyc >= 20) drive();
      else begin set_in = 4'hF; clr_in = 4'h0; end
      if (cyc == 1500) begin
        #2 resetedge = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
          check($sformatf("arst_q%0d", k),   dq[k],   4'h0);
          check($sformatf("arst_sp%0d", k),  dsp[k],  4'h0);
          check($sformatf("arst_cp%0d", k),  dcp[k],  4'h0);
          check($sformatf("arst_tp%0d", k),  dtp[k],  4'h0);
          check($sformatf("arst_any%0d", k), dany[k], 1'b0);
        end
      end
    end
    check("timeouts_exercised", 32'(tmo_seen > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edgesr_bank.md
# edgesr_bank

Multi-channel, clock-synchronous edge-triggered set/reset register bank. Each channel has its own set and clear inputs, asynchronous to `clk`. The block synchronises them, detects edges of a configurable polarity, and holds a per-channel output level. It adds an optional auto-clear timeout, per-channel event pulses and an aggregate flag. It sits between asynchronous board/strobe inputs and the synchronous status and interrupt logic of the controller.

## Interface
- `CHANNELS`, 4: number of independent channels (1..32).
- `SYNC_STAGES`, 2: synchroniser depth per input (minimum 2).
- `SET_EDGE`, 0: set-input edge select. 0 = rising, 1 = falling, 2 = both.
- `CLR_EDGE`, 0: clear-input edge select, same encoding as `SET_EDGE`.
- `SET_PRIORITY`, 1: on a simultaneous set and clear edge, 1 = set wins, 0 = clear wins.
- `TIMEOUT`, 0: auto-clear after this many `clk` cycles high. 0 = disabled. Max 2^16-1.
- `RETRIG`, 1: a set edge while the output is already high restarts the timeout counter (1) or is ignored by the counter (0).

- `clk` in 1: block clock; all state updates on its rising edge.
- `resetedge` in 1: reset, asynchronous, active-high.
- `set_in` in CHANNELS: per-channel set inputs, asynchronous to `clk`.
- `clr_in` in CHANNELS: per-channel clear inputs, asynchronous to `clk`.
- `q` in/out: `q` out CHANNELS: per-channel held level.
- `set_pulse` out CHANNELS: one-cycle pulse when a channel's `q` goes 0->1.
- `clr_pulse` out CHANNELS: one-cycle pulse when a channel's `q` goes 1->0, from a clear edge or timeout.
- `tmo_pulse` out CHANNELS: one-cycle pulse when a timeout clears a channel.
- `any_q` out 1: registered OR of all `q` bits.

## Operation
- **Reset state:** while `resetedge`=1, every synchroniser flop, edge-history flop, `q`, pulse output, counter and `any_q` is 0, and `armed` is 0.
- **Synchroniser:** `set_in[i]` and `clr_in[i]` each pass through a SYNC_STAGES flop chain, followed by one history flop.
- **Edge detect:** compares the last sync stage with the history flop.
  - Rising edge = 1 now, 0 before. Falling edge = 0 now, 1 before. Both = either.
- **Arming:** a global counter sets `armed` SYNC_STAGES+1 cycles after reset release.
  - Edges are ignored until `armed`=1, so inputs that are static-high at reset release produce no events.
- **Per-channel next state, evaluated in priority order:**
  1. Set and clear edges in the same cycle: resolve by SET_PRIORITY.
  2. Set edge: `q`<=1. Counter loads 0 if `q` was 0, or if RETRIG=1.
  3. Clear edge: `q`<=0 and counter <=0.
  4. TIMEOUT!=0, `q`=1 and counter = TIMEOUT-1: `q`<=0, `tmo_pulse`<=1, counter <=0.
  5. `q`=1 and TIMEOUT!=0: counter increments.
- **Set edge vs. timeout:** a set edge arriving in the same cycle as timeout expiry wins. `q` stays 1, no pulses fire, and the counter reloads 0.
- **Edge on a channel already in that state:** a set edge with `q`=1, or a clear edge with `q`=0, changes nothing and produces no pulse.
- **Pulses:** `set_pulse` and `clr_pulse` are registered and derived from the actual `q` transition, so they are never both high on one channel. `tmo_pulse` implies `clr_pulse` in the same cycle.
- **Counter width:** the counter is 16 bits and saturation is never reached. When TIMEOUT=0 the counter logic is removed.

## Timing
- **Input-to-output latency:** an input change that meets setup before rising edge k is seen in the last sync stage after edge k+SYNC_STAGES-1.
  - `q` and the pulses update at edge k+SYNC_STAGES.
  - `any_q` updates at edge k+SYNC_STAGES+1.
- **Minimum input pulse width:** 2 `clk` periods high and 2 low, for every edge to be captured. Shorter pulses may be lost; the block does not need to detect them.
- **Timeout:** `q` stays high for exactly TIMEOUT cycles after the cycle it rose, with no retrigger. `tmo_pulse` is high in the cycle `q` falls.
- **Mid-operation reset:** asserting `resetedge` mid-operation clears all state immediately and asynchronously. Release must be synchronised externally to `clk`. Re-arming follows the arming rule above.

## Test plan
- **Basic set/clear:** CHANNELS=4, SYNC_STAGES=2. Rising edge on `set_in[2]` before edge k -> `q`=4'b0100 and `set_pulse[2]` high at edge k+2 for one cycle; `any_q`=1 at edge k+3. Then a rising edge on `clr_in[2]` -> `q`=0 and one `clr_pulse[2]`.
- **Simultaneous edges:** rising edges on `set_in[0]` and `clr_in[0]` in the same cycle.
  - SET_PRIORITY=1 -> `q[0]`=1.
  - SET_PRIORITY=0 -> `q[0]` stays 0 with no pulse.
- **Timeout:** TIMEOUT=10. Set `q[1]` -> `q[1]` high exactly 10 cycles, then `tmo_pulse[1]` and `clr_pulse[1]` for 1 cycle.
  - RETRIG=1 with a second set edge at cycle 6 -> high for 16 cycles total.
  - RETRIG=0 -> high for 10 cycles.
- **Arming:** hold `set_in`=4'b1111 high through reset release with SET_EDGE=0 -> `q` stays 0 and no `set_pulse`. Then drop and raise `set_in[3]` -> `q[3]`=1.
- **Falling/both modes:** SET_EDGE=1 -> only the high-to-low transition of `set_in` sets `q`. SET_EDGE=2 with two `set_in` toggles -> one `set_pulse`, `q` stays 1.
- **Reset mid-operation:** `q`=4'b1011 with a timeout counting; assert `resetedge` asynchronously -> all outputs 0 before the next `clk` edge, and no pulses after release.
